cnna_fm_addr_gen: RTL

Feature-map address generator for the CNN accelerator's line-buffer read path. It accepts one tile descriptor (base, row count, row stride) and walks every word of the tile row-major, emitting `base + row*stride + col` as a 16-bit buffer address over a valid/ready stream. The row term comes from a 15-bit × 5-bit unsigned multiplier truncated to 16 bits. The block sits directly upstream of the feature-map buffer read port.

---
 rtl/cnna_pkg.sv | 20 ++
 rtl/cnna_addr_row_mul.sv | 16 +
 rtl/cnna_fm_addr_gen.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cnna_pkg.sv
// Shared constants and types for the CNN accelerator feature-map path.
package cnna_pkg;

    localparam int unsigned CNNA_ROW_W    = 15;
    localparam int unsigned CNNA_STRIDE_W = 5;
    localparam int unsigned CNNA_ADDR_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } addr_gen_state_t;

    typedef struct packed {
        logic [CNNA_ADDR_W-1:0]   base;
        logic [CNNA_ROW_W-1:0]    rows;
        logic [CNNA_STRIDE_W-1:0] stride;
    } fm_desc_t;

endpackage

// File: rtl/cnna_addr_row_mul.sv
// Unsigned row * stride multiplier, truncated to the address width.
// Purely combinational; the caller registers the product.
module cnna_addr_row_mul #(
    parameter int unsigned ROW_W    = 15,
    parameter int unsigned STRIDE_W = 5,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic [ROW_W-1:0]    row,
    input  logic [STRIDE_W-1:0] stride,
    output logic [ADDR_W-1:0]   prod
);

    // Multiplying at ADDR_W width yields the product modulo 2^ADDR_W directly.
    assign prod = ADDR_W'(row) * ADDR_W'(stride);

endmodule

// File: rtl/cnna_fm_addr_gen.sv
// Feature-map address generator: walks one tile row-major and streams
// base + row*stride + col through a two-stage stallable pipeline.
module cnna_fm_addr_gen
    import cnna_pkg::*;
#(
    parameter int unsigned ROW_W    = CNNA_ROW_W,
    parameter int unsigned STRIDE_W = CNNA_STRIDE_W,
    parameter int unsigned ADDR_W   = CNNA_ADDR_W
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ROW_W-1:0]    cfg_rows,
    input  logic [STRIDE_W-1:0] cfg_stride,
    output logic                addr_valid,
    input  logic                addr_ready,
    output logic [ADDR_W-1:0]   addr_data,
    output logic                addr_last,
    output logic                done
);

    addr_gen_state_t       state_q;
    fm_desc_t              desc_q;
    logic [ROW_W-1:0]      r_q;
    logic [STRIDE_W-1:0]   c_q;
    logic                  s1_valid_q;
    logic                  s1_last_q;
    logic [ADDR_W-1:0]     s1_p_q;
    logic [STRIDE_W-1:0]   s1_c_q;

    logic                  en;
    logic                  inject;
    logic                  c_wrap;
    logic                  is_last;
    logic [ADDR_W-1:0]     row_off;

    always_comb begin
        en      = !addr_valid | addr_ready;
        inject  = (state_q == RUN) & en;
        c_wrap  = (c_q == desc_q.stride - STRIDE_W'(1));
        is_last = (r_q == desc_q.rows - ROW_W'(1)) & c_wrap;
    end

    assign cfg_ready = (state_q == IDLE);

    cnna_addr_row_mul #(
        .ROW_W    (ROW_W),
        .STRIDE_W (STRIDE_W),
        .ADDR_W   (ADDR_W)
    ) u_row_mul (
        .row    (r_q),
        .stride (desc_q.stride),
        .prod   (row_off)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= IDLE;
            desc_q     <= '0;
            r_q        <= '0;
            c_q        <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_p_q     <= '0;
            s1_c_q     <= '0;
            addr_valid <= 1'b0;
            addr_last  <= 1'b0;
            addr_data  <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg_valid) begin
                        desc_q <= '{base: cfg_base, rows: cfg_rows, stride: cfg_stride};
                        r_q    <= '0;
                        c_q    <= '0;
                        // Empty tile: skip RUN, DRAIN only exists to hold the done cycle.
                        if (cfg_rows == '0 || cfg_stride == '0) begin
                            state_q <= DRAIN;
                            done    <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        if (c_wrap) begin
                            c_q <= '0;
                            r_q <= r_q + ROW_W'(1);
                        end else begin
                            c_q <= c_q + STRIDE_W'(1);
                        end
                        if (is_last) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave only after done has been visible for one cycle.
                    if (done) begin
                        state_q <= IDLE;
                    end else if (addr_valid & addr_ready & addr_last) begin
                        done <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (en) begin
                s1_valid_q <= inject;
                s1_last_q  <= inject & is_last;
                s1_p_q     <= row_off;
                s1_c_q     <= c_q;
                addr_valid <= s1_valid_q;
                addr_last  <= s1_last_q;
                if (s1_valid_q) addr_data <= desc_q.base + s1_p_q + ADDR_W'(s1_c_q);
            end
        end
    end

endmodule
